// File: rtl/song_data_server.sv
// song_data_server: looks up a song in a byte-ROM directory and serves its bytes one request at a time.
module song_data_server #(
  parameter int rom_addr_width = 16,
  parameter int dir_entry_bytes = 4
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      restart,
  input  logic [7:0]                init_index,
  input  logic [7:0]                init_aux_info,
  input  logic                      request_data,
  output logic                      data_ready,
  output logic [7:0]                cpu_data_in,
  output logic                      transmit_finished,
  output logic [rom_addr_width-1:0] rom_addr,
  output logic                      rom_en,
  input  logic [7:0]                rom_data,
  output logic                      busy,
  output logic                      overrun
);
  localparam logic [2:0] IDLE = 3'd0, DIR = 3'd1, READY = 3'd2, FETCH = 3'd3,
                         WAIT = 3'd4, RESP = 3'd5, DONE = 3'd6;
  logic [2:0] st, cnt;
  logic [7:0] idx, base_hi, base_lo, len_hi, len_lo;
  logic pre_on, pending, is_pre, dir_end, last, accept, consume, to_done, unused_aux;
  logic [16:0] len_total, sent, pre, new_total;
  logic [rom_addr_width-1:0] addr_q, dir_addr, fetch_addr;
  assign unused_aux = ^init_aux_info[7:1];
  always_comb begin
    pre = pre_on ? 17'd2 : 17'd0;
    is_pre = sent < pre;
    new_total = {1'b0, len_hi, rom_data} + pre;
    dir_end = st == DIR && cnt == 3'd4;
    last = sent + 17'd1 == len_total;
    accept = request_data && st != IDLE && st != DONE;
    consume = pending && (st == READY || (st == RESP && !last) || (dir_end && new_total != 17'd0));
    to_done = (dir_end && new_total == 17'd0) || (st == RESP && last);
    dir_addr = rom_addr_width'(idx * dir_entry_bytes) + rom_addr_width'(cnt);
    fetch_addr = rom_addr_width'({base_hi, base_lo}) + rom_addr_width'(sent - pre);
    rom_en = (st == DIR && cnt < 3'd4) || (st == FETCH && !is_pre);
    rom_addr = !rom_en ? addr_q : st == DIR ? dir_addr : fetch_addr;
    data_ready = st == RESP;
    busy = st == DIR || st == FETCH || st == WAIT || st == RESP;
    transmit_finished = st == DONE || (st == RESP && last);
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      st <= IDLE;
      cnt <= '0;
      idx <= '0;
      pre_on <= 1'b0;
      base_hi <= '0;
      base_lo <= '0;
      len_hi <= '0;
      len_lo <= '0;
      len_total <= '0;
      sent <= '0;
      pending <= 1'b0;
      overrun <= 1'b0;
      addr_q <= '0;
      cpu_data_in <= '0;
    end else if (restart) begin
      st <= DIR;
      cnt <= '0;
      idx <= init_index;
      pre_on <= init_aux_info[0];
      pending <= 1'b0;
      overrun <= 1'b0;
      addr_q <= rom_addr;
    end else begin
      addr_q <= rom_addr;
      // a request consumed on this edge frees the slot for one arriving on the same edge
      pending <= to_done ? 1'b0 : consume ? accept : pending | accept;
      overrun <= overrun | (accept & pending & ~consume);
      case (st)
        DIR: begin
          cnt <= cnt + 3'd1;
          if (cnt == 3'd1) base_hi <= rom_data;
          if (cnt == 3'd2) base_lo <= rom_data;
          if (cnt == 3'd3) len_hi <= rom_data;
          if (dir_end) begin
            len_lo <= rom_data;
            len_total <= new_total;
            sent <= '0;
            st <= new_total == 17'd0 ? DONE : pending ? FETCH : READY;
          end
        end
        READY: st <= pending ? FETCH : READY;
        FETCH: st <= WAIT;
        WAIT: begin
          cpu_data_in <= is_pre ? (sent[0] ? len_lo : len_hi) : rom_data;
          st <= RESP;
        end
        RESP: begin
          sent <= sent + 17'd1;
          st <= last ? DONE : pending ? FETCH : READY;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_song_data_server.sv
// tb_song_data_server: directed bench with a byte-queue reference model of song_data_server.
module tb_song_data_server;
  localparam int BIG = 1 << 30;
  logic clk = 1'b0;
  logic RESET, restart, request_data, data_ready, transmit_finished, rom_en, busy, overrun;
  logic [7:0] init_index, init_aux_info, cpu_data_in, rom_data;
  logic [15:0] rom_addr;
  logic [7:0] rom [0:65535];
  int vectors = 0, miscompares = 0;
  int edge_n = 0, s = 0, last_p = 0, pa = 0, pc = 0, tf_edge = BIG, ovr_edge = BIG, ren_cnt = 0;
  bit active = 0;
  logic [7:0] bq [$];
  logic [7:0] got_q [$];
  logic [15:0] rd_q [$];
  logic [7:0] exp_at [int];

  song_data_server dut (
    .CLK(clk), .RESET(RESET), .restart(restart), .init_index(init_index),
    .init_aux_info(init_aux_info), .request_data(request_data), .data_ready(data_ready),
    .cpu_data_in(cpu_data_in), .transmit_finished(transmit_finished), .rom_addr(rom_addr),
    .rom_en(rom_en), .rom_data(rom_data), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (rom_en) rom_data <= rom[rom_addr];

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a > b ? a : b;
    return m > c ? m : c;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // model: a song is a byte queue; each accepted request gets the next byte 3 edges later,
  // no sooner than 3 edges after the previous byte, and at most one request may wait
  always @(posedge clk) begin
    int a, p;
    logic [15:0] base, len;
    edge_n++;
    if (RESET) begin
      active = 0;
      exp_at.delete();
      bq.delete();
      tf_edge = BIG;
      ovr_edge = BIG;
    end else if (restart) begin
      s = edge_n;
      active = 1;
      exp_at.delete();
      bq.delete();
      ovr_edge = BIG;
      last_p = -100;
      pa = -100;
      pc = -100;
      a = int'(init_index) * 4;
      base = {rom[a], rom[a+1]};
      len = {rom[a+2], rom[a+3]};
      if (init_aux_info[0]) begin
        bq.push_back(len[15:8]);
        bq.push_back(len[7:0]);
      end
      for (int j = 0; j < int'(len); j++) bq.push_back(rom[16'(int'(base) + j)]);
      tf_edge = bq.size() == 0 ? s + 5 : BIG;
    end else if (request_data && active && bq.size() > 0) begin
      if (pa < edge_n && edge_n < pc) begin
        if (ovr_edge == BIG) ovr_edge = edge_n;
      end else begin
        p = max3(edge_n + 3, s + 7, last_p + 3);
        exp_at[p] = bq.pop_front();
        last_p = p;
        pa = edge_n;
        pc = p - 2;
        if (bq.size() == 0) tf_edge = p;
      end
    end
  end

  always @(negedge clk) begin
    bit exp_dr;
    if (!RESET) begin
      exp_dr = exp_at.exists(edge_n);
      chk("data_ready", int'(data_ready), int'(exp_dr));
      if (exp_dr) chk("cpu_data_in", int'(cpu_data_in), int'(exp_at[edge_n]));
      chk("transmit_finished", int'(transmit_finished), int'(edge_n >= tf_edge));
      chk("overrun", int'(overrun), int'(edge_n >= ovr_edge));
      if (data_ready) got_q.push_back(cpu_data_in);
      if (rom_en) begin
        rd_q.push_back(rom_addr);
        ren_cnt++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic restart_song(input logic [7:0] i, input logic [7:0] a);
    restart = 1;
    init_index = i;
    init_aux_info = a;
    tick(1);
    restart = 0;
  endtask

  task automatic req_check(input string nm, input logic [7:0] b, input logic t);
    request_data = 1;
    tick(1);
    request_data = 0;
    tick(2);
    chk({nm, " early"}, int'(data_ready), 0);
    tick(1);
    chk({nm, " pulse"}, int'(data_ready), 1);
    chk({nm, " byte"}, int'(cpu_data_in), int'(b));
    chk({nm, " finished"}, int'(transmit_finished), int'(t));
    tick(2);
  endtask

  initial begin
    int n, c0;
    RESET = 1;
    restart = 0;
    request_data = 0;
    init_index = 0;
    init_aux_info = 0;
    for (int i = 0; i < 65536; i++) rom[i] = 8'h00;
    {rom[0], rom[1], rom[2], rom[3]} = 32'h0100_0003;
    {rom[4], rom[5], rom[6], rom[7]} = 32'h0200_0002;
    {rom[8], rom[9], rom[10], rom[11]} = 32'h0300_000F;
    {rom[16], rom[17], rom[18], rom[19]} = 32'hFFFF_0002;
    {rom[256], rom[257], rom[258]} = 24'hA1A2A3;
    {rom[512], rom[513]} = 16'hB1B2;
    for (int j = 0; j < 15; j++) rom[768 + j] = 8'(j + 1);
    rom[65535] = 8'hC1;
    tick(3);
    chk("reset data_ready", int'(data_ready), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset finished", int'(transmit_finished), 0);
    chk("reset overrun", int'(overrun), 0);
    chk("reset rom_en", int'(rom_en), 0);
    chk("reset rom_addr", int'(rom_addr), 0);
    chk("reset cpu_data_in", int'(cpu_data_in), 0);
    RESET = 0;
    tick(2);
    // basic transfer
    restart_song(8'd0, 8'd0);
    chk("dir busy", int'(busy), 1);
    tick(8);
    req_check("basic 0", 8'hA1, 0);
    req_check("basic 1", 8'hA2, 0);
    req_check("basic 2", 8'hA3, 1);
    n = got_q.size();
    request_data = 1;
    tick(1);
    request_data = 0;
    tick(8);
    chk("request after done", got_q.size(), n);
    // length prefix
    c0 = ren_cnt;
    restart_song(8'd0, 8'd1);
    tick(8);
    req_check("prefix 0", 8'h00, 0);
    req_check("prefix 1", 8'h03, 0);
    req_check("prefix 2", 8'hA1, 0);
    req_check("prefix 3", 8'hA2, 0);
    req_check("prefix 4", 8'hA3, 1);
    chk("prefix rom reads", ren_cnt - c0, 7);
    // back-to-back requests, then an overrun
    n = got_q.size();
    restart_song(8'd2, 8'd0);
    for (int i = 0; i < 12; i++) begin
      request_data = 1;
      tick(1);
      request_data = 0;
      tick(3);
    end
    tick(4);
    chk("b2b count", got_q.size() - n, 12);
    for (int i = 0; i < 12; i++) chk("b2b byte", int'(got_q[n + i]), i + 1);
    chk("b2b no overrun", int'(overrun), 0);
    request_data = 1;
    tick(3);
    request_data = 0;
    tick(10);
    chk("burst overrun", int'(overrun), 1);
    chk("burst count", got_q.size() - n, 14);
    chk("burst last byte", int'(got_q[got_q.size() - 1]), 14);
    // empty song
    n = got_q.size();
    restart_song(8'd3, 8'd0);
    tick(4);
    chk("empty finished early", int'(transmit_finished), 0);
    tick(1);
    chk("empty finished", int'(transmit_finished), 1);
    request_data = 1;
    tick(1);
    request_data = 0;
    tick(6);
    chk("empty no data", got_q.size(), n);
    // abort mid-transfer
    restart_song(8'd0, 8'd0);
    tick(7);
    req_check("abort 0", 8'hA1, 0);
    req_check("abort 1", 8'hA2, 0);
    restart_song(8'd1, 8'd0);
    tick(7);
    req_check("song1 0", 8'hB1, 0);
    n = got_q.size();
    restart = 1;
    request_data = 1;
    init_index = 8'd0;
    tick(1);
    restart = 0;
    request_data = 0;
    tick(10);
    chk("restart beats request", got_q.size(), n);
    // address wrap
    restart_song(8'd4, 8'd0);
    tick(7);
    n = rd_q.size();
    req_check("wrap 0", 8'hC1, 0);
    req_check("wrap 1", 8'h01, 1);
    chk("wrap reads", rd_q.size() - n, 2);
    chk("wrap addr 0", int'(rd_q[n]), 16'hFFFF);
    chk("wrap addr 1", int'(rd_q[n + 1]), 16'h0000);
    // asynchronous reset during WAIT
    restart_song(8'd4, 8'd0);
    tick(7);
    request_data = 1;
    tick(1);
    request_data = 0;
    tick(2);
    chk("wait busy", int'(busy), 1);
    RESET = 1;
    #1;
    chk("async data_ready", int'(data_ready), 0);
    chk("async busy", int'(busy), 0);
    chk("async finished", int'(transmit_finished), 0);
    chk("async rom_en", int'(rom_en), 0);
    tick(2);
    RESET = 0;
    tick(4);
    chk("post reset busy", int'(busy), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/song_data_server.md
Name: song_data_server

Overview:
- CPU-side responder for the song-data loader handshake: restart, init_index, init_aux_info, request_data, data_ready, cpu_data_in, transmit_finished.
- On restart it looks up a song in a directory stored in an external byte ROM.
- It then returns one byte per request and flags end of transfer.
- Sits between the song ROM and the BRAM data loader, and replaces the software CPU in standalone builds.

Parameters:
- rom_addr_width, 16, byte-address width of the song ROM
- dir_entry_bytes, 4, directory entry size in bytes; entry i starts at i*dir_entry_bytes

Ports:
- CLK  input  1  system clock
- RESET  input  1  asynchronous, active-high reset
- restart  input  1  one-cycle pulse; begin a new transfer
- init_index  input  8  song index; sampled with restart
- init_aux_info  input  8  mode bits; sampled with restart; bit0 = prepend length
- request_data  input  1  one-cycle pulse; one byte wanted
- data_ready  output  1  one-cycle pulse; cpu_data_in valid
- cpu_data_in  output  8  returned byte, held until the next byte
- transmit_finished  output  1  level; all bytes delivered
- rom_addr  output  rom_addr_width  ROM byte address
- rom_en  output  1  ROM read enable; data valid the next cycle
- rom_data  input  8  ROM read data
- busy  output  1  directory lookup or fetch in progress
- overrun  output  1  sticky; a request was dropped

Behaviour:
- Reset: all outputs and registers 0; state IDLE.
- Directory entry for index i at address i*dir_entry_bytes, byte order: base_hi, base_lo, len_hi, len_lo.
  - base is rom_addr_width bits.
  - len is 16 bits.
- States:
  - IDLE: request_data ignored; restart -> DIR.
  - DIR: 4 ROM reads on consecutive cycles, registers filled one cycle after each read; then len_total = len + (aux[0] ? 2 : 0) and sent = 0.
    - len_total == 0 -> DONE.
    - Otherwise -> READY, or -> FETCH if a request is pending.
  - READY: request_data -> FETCH.
  - FETCH: one ROM read at (base + sent - prefix) mod 2^rom_addr_width, where prefix = 2 if aux[0] else 0.
    - While sent < prefix, no ROM read is issued and the byte comes from len (hi first, then lo); latency is identical.
  - WAIT: ROM data returns.
  - RESP: cpu_data_in <= byte; data_ready = 1 for one cycle; sent += 1.
    - sent == len_total -> DONE.
    - Pending request -> FETCH.
    - Otherwise -> READY.
  - DONE: transmit_finished = 1 until restart or reset; request_data ignored.
- Latency: request_data sampled high on edge k -> data_ready high in the cycle after edge k+3, which is the RESP cycle. Fixed for every byte.
- Pending requests:
  - One request arriving during DIR, FETCH, WAIT or RESP is latched as pending.
  - A further request while one is already pending is dropped and sets overrun.
- restart in any state:
  - Aborts the current transfer, clears pending, transmit_finished, data_ready and overrun.
  - Re-samples index and aux, then -> DIR next cycle.
  - restart beats a simultaneous request_data; that request is discarded.
- busy = 1 in DIR, FETCH, WAIT and RESP.
- rom_en is high only in cycles that issue a read; rom_addr is held otherwise.
- Mid-operation RESET clears everything asynchronously; the transfer must be restarted.

Test Plan:
- Basic transfer: ROM entry 0 = {0x01,0x00,0x00,0x03}, bytes 0x100..0x102 = A1,A2,A3; restart (index 0, aux 0), then 3 requests spaced ≥5 cycles -> data_ready pulses exactly 3 cycles after each request, values A1,A2,A3; transmit_finished rises with the third pulse; a 4th request gives no pulse.
- Length prefix: same entry with aux = 0x01 -> 5 bytes returned: 00,03,A1,A2,A3; no rom_en during the first two fetches.
- Back-to-back requests: request 1 cycle after restart, then 12 requests every 4 cycles (byte values 1..12) -> all 12 returned in order, overrun = 0; three requests on consecutive cycles -> the third is dropped and overrun = 1.
- Empty song: len = 0 -> transmit_finished high 5 cycles after restart; no data_ready.
- Abort: restart (index 1) after 2 of 3 bytes of song 0 -> next byte is the first byte of song 1; transmit_finished stays 0; a simultaneous restart and request gives no data_ready.
- Wrap and reset: base = 0xFFFF, len = 2 -> reads at 0xFFFF then 0x0000; asserting RESET during WAIT clears data_ready, busy and transmit_finished immediately, without waiting for a clock edge.
